// File: rtl/and_unit_arbiter.sv
// ---------------------------------------------------------------------------
// and_unit_arbiter
//
// Purpose:
//   Lets NUM_REQ requesters share one external combinational AND datapath
//   (and_4bit). A round-robin arbiter picks a requester. Its operands are
//   registered onto op_a/op_b, and the datapath result on op_c is captured.
//   The result is returned on a single response channel, tagged with the
//   requester id. Every result is also compared against an internal A&B.
//   A sticky flag and a saturating counter record any disagreement.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]        per-requester request valid
//   req_ready  out  [NUM_REQ]        per-requester accept (one-hot or zero)
//   req_a      in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NUM_REQ*WIDTH]  operand B, same packing
//   op_a       out  [WIDTH]          to datapath A
//   op_b       out  [WIDTH]          to datapath B
//   op_c       in   [WIDTH]          from datapath C
//   rsp_valid  out                   response valid
//   rsp_ready  in                    response consumer ready
//   rsp_id     out  [ID_W]           owner of the response
//   rsp_data   out  [WIDTH]          captured datapath result
//   chk_err    out                   sticky datapath-mismatch flag
//   err_count  out  [ERR_W]          saturating mismatch count
//   busy       out                   FSM not idle
// ---------------------------------------------------------------------------
module and_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           op_a,
    output logic [WIDTH-1:0]           op_b,
    input  logic [WIDTH-1:0]           op_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       chk_err,
    output logic [ERR_W-1:0]           err_count,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   op_a_q,       op_a_d;
    logic [WIDTH-1:0]   op_b_q,       op_b_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q,   rsp_data_d;
    logic               chk_err_q,    chk_err_d;
    logic [ERR_W-1:0]   err_count_q,  err_count_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    scan_id;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Round-robin scan starting just after the last winner. The first valid
    // requester found in that rotated order wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_id     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_id = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_idx   = scan_id;
            end
        end
    end

    assign sel_a = req_a[grant_idx*WIDTH +: WIDTH];
    assign sel_b = req_b[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        chk_err_d    = chk_err_q;
        err_count_d  = err_count_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d       = sel_a;
                    op_b_d       = sel_b;
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = op_c;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
                // The case-inequality treats any X/Z on op_c as a mismatch.
                if (op_c !== (op_a_q & op_b_q)) begin
                    chk_err_d = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            chk_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            chk_err_q    <= chk_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign chk_err   = chk_err_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != IDLE);

endmodule
